// File: rtl/sysram_ctrl_if.sv
// Bundles the requester handshakes and the RAM-side control lines of the
// system RAM sequencer; the controller sits on the slave modport.
interface sysram_ctrl_if #(
   parameter int ADDR_W = 5
);
   logic              alu_wr_req;
   logic [ADDR_W-1:0] alu_addr;
   logic              port_wr_req;
   logic [ADDR_W-1:0] port_addr;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [2:0]        gnt;
   logic [2:0]        ack;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic              RAM_CS;
   logic              RAM_OE;
   logic              WR_STB;
   logic              RDR_EN;
   logic              ALU_DRV_EN;
   logic              PORT_DRV_EN;
   logic              busy;

   modport master (
      output alu_wr_req, alu_addr, port_wr_req, port_addr, rd_req, rd_addr,
      input  gnt, ack, RAM_ADDR, RAM_CS, RAM_OE, WR_STB, RDR_EN,
             ALU_DRV_EN, PORT_DRV_EN, busy
   );

   modport slave (
      input  alu_wr_req, alu_addr, port_wr_req, port_addr, rd_req, rd_addr,
      output gnt, ack, RAM_ADDR, RAM_CS, RAM_OE, WR_STB, RDR_EN,
             ALU_DRV_EN, PORT_DRV_EN, busy
   );
endinterface

// File: rtl/sysram_ctrl.sv
// Round-robin sequencer for the shared RAM data bus: grants ALU write, port
// write or RDR read one at a time and drives RAM/tri-state strobes from state.
module sysram_ctrl #(
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = 5
) (
   input logic         clk,
   input logic         rst,
   sysram_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, SETUP, STROBE, HOLD, READ, LATCH, TURN
   } state_e;

   localparam logic [2:0] WaitLoad = 3'(WAIT_STATES);

   state_e            state_q, state_d;
   logic [2:0]        waitCnt_q, waitCnt_d;
   logic [1:0]        lastGrant_q, lastGrant_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;

   logic cs_q, cs_d;
   logic oe_q, oe_d;
   logic wrStb_q, wrStb_d;
   logic rdrEn_q, rdrEn_d;
   logic aluDrv_q, aluDrv_d;
   logic portDrv_q, portDrv_d;
   logic busy_q, busy_d;
   logic [2:0] ack_q, ack_d;

   logic [2:0]        reqVec;
   logic [1:0]        cand0, cand1, cand2;
   logic              winValid;
   logic [1:0]        winIdx;
   logic [ADDR_W-1:0] winAddr;

   function automatic logic [1:0] nextIdx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   assign reqVec = {bus.rd_req, bus.port_wr_req, bus.alu_wr_req};

   // Search starts just after the last winner, so every requester is reached
   // within three grants no matter what the others keep asserting.
   always_comb begin
      cand0    = nextIdx(lastGrant_q);
      cand1    = nextIdx(cand0);
      cand2    = lastGrant_q;
      winValid = 1'b1;
      winIdx   = cand0;
      if (reqVec[cand0]) begin
         winIdx = cand0;
      end else if (reqVec[cand1]) begin
         winIdx = cand1;
      end else if (reqVec[cand2]) begin
         winIdx = cand2;
      end else begin
         winValid = 1'b0;
      end
      unique case (winIdx)
         2'd0:    winAddr = bus.alu_addr;
         2'd1:    winAddr = bus.port_addr;
         default: winAddr = bus.rd_addr;
      endcase
   end

   // State register together with the grant bookkeeping it owns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         waitCnt_q   <= 3'd0;
         lastGrant_q <= 2'd2;
         gnt_q       <= 3'b000;
         ramAddr_q   <= '0;
      end else begin
         state_q     <= state_d;
         waitCnt_q   <= waitCnt_d;
         lastGrant_q <= lastGrant_d;
         gnt_q       <= gnt_d;
         ramAddr_q   <= ramAddr_d;
      end
   end

   // Next-state logic; requests are only looked at in IDLE.
   always_comb begin
      state_d     = state_q;
      waitCnt_d   = waitCnt_q;
      lastGrant_d = lastGrant_q;
      gnt_d       = gnt_q;
      ramAddr_d   = ramAddr_q;
      unique case (state_q)
         IDLE: begin
            if (winValid) begin
               gnt_d       = 3'b001 << winIdx;
               lastGrant_d = winIdx;
               ramAddr_d   = winAddr;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            waitCnt_d = WaitLoad;
            state_d   = gnt_q[2] ? READ : STROBE;
         end
         STROBE: begin
            if (waitCnt_q == 3'd0) begin
               state_d = HOLD;
            end else begin
               waitCnt_d = waitCnt_q - 3'd1;
            end
         end
         READ: begin
            if (waitCnt_q == 3'd0) begin
               state_d = LATCH;
            end else begin
               waitCnt_d = waitCnt_q - 3'd1;
            end
         end
         HOLD, LATCH: begin
            state_d = TURN;
            gnt_d   = 3'b000;
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state and registered, so every
   // strobe changes on the same edge as the state it belongs to.
   always_comb begin
      cs_d      = state_d inside {SETUP, STROBE, HOLD, READ, LATCH};
      oe_d      = state_d inside {READ, LATCH};
      wrStb_d   = (state_d == STROBE);
      rdrEn_d   = (state_d == LATCH);
      aluDrv_d  = gnt_d[0] && (state_d inside {SETUP, STROBE, HOLD});
      portDrv_d = gnt_d[1] && (state_d inside {SETUP, STROBE, HOLD});
      busy_d    = (state_d != IDLE);
      ack_d     = (state_d == TURN) ? gnt_q : 3'b000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q      <= 1'b0;
         oe_q      <= 1'b0;
         wrStb_q   <= 1'b0;
         rdrEn_q   <= 1'b0;
         aluDrv_q  <= 1'b0;
         portDrv_q <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 3'b000;
      end else begin
         cs_q      <= cs_d;
         oe_q      <= oe_d;
         wrStb_q   <= wrStb_d;
         rdrEn_q   <= rdrEn_d;
         aluDrv_q  <= aluDrv_d;
         portDrv_q <= portDrv_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.ack         = ack_q;
   assign bus.RAM_ADDR    = ramAddr_q;
   assign bus.RAM_CS      = cs_q;
   assign bus.RAM_OE      = oe_q;
   assign bus.WR_STB      = wrStb_q;
   assign bus.RDR_EN      = rdrEn_q;
   assign bus.ALU_DRV_EN  = aluDrv_q;
   assign bus.PORT_DRV_EN = portDrv_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sysram_ctrl.sv
// Directed bench for sysram_ctrl: one instance with no wait states, one with
// two, a scoreboard of expected grants and per-cycle bus-contention checks.
module tb_sysram_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sysram_ctrl_if #(.ADDR_W(5)) bus0 ();
   sysram_ctrl_if #(.ADDR_W(5)) bus2 ();

   sysram_ctrl #(.WAIT_STATES(0), .ADDR_W(5)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   sysram_ctrl #(.WAIT_STATES(2), .ADDR_W(5)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   typedef struct packed {
      logic [2:0] g;
      logic [4:0] a;
   } exp_t;

   exp_t sb0[$];
   exp_t sb2[$];
   exp_t e0, e2;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkInvariants(input string nm, input logic aluDrv, input logic portDrv,
                                  input logic oe, input logic cs, input logic wrStb,
                                  input logic rdrEn, input logic busy, input logic [2:0] ack);
      checkOutput({nm, "_drv_excl"}, 8'(aluDrv & portDrv), 8'h00);
      checkOutput({nm, "_oe_vs_drv"}, 8'(oe & (aluDrv | portDrv)), 8'h00);
      checkOutput({nm, "_stb_owner"}, 8'(!wrStb || (cs && (aluDrv ^ portDrv))), 8'h01);
      checkOutput({nm, "_rdr_oe"}, 8'(!rdrEn || oe), 8'h01);
      checkOutput({nm, "_busy"}, 8'(busy), 8'(cs | (|ack)));
   endtask

   // Per-cycle invariants plus scoreboard retirement on every ack pulse.
   always @(negedge clk) begin
      checkInvariants("b0", bus0.ALU_DRV_EN, bus0.PORT_DRV_EN, bus0.RAM_OE, bus0.RAM_CS,
                      bus0.WR_STB, bus0.RDR_EN, bus0.busy, bus0.ack);
      checkInvariants("b2", bus2.ALU_DRV_EN, bus2.PORT_DRV_EN, bus2.RAM_OE, bus2.RAM_CS,
                      bus2.WR_STB, bus2.RDR_EN, bus2.busy, bus2.ack);
      if (bus0.ack != 3'b000) begin
         if (sb0.size() == 0) begin
            checkOutput("sb0_unexpected_ack", 8'(bus0.ack), 8'h00);
         end else begin
            e0 = sb0.pop_front();
            checkOutput("sb0_ack", 8'(bus0.ack), 8'(e0.g));
            checkOutput("sb0_addr", 8'(bus0.RAM_ADDR), 8'(e0.a));
         end
      end
      if (bus2.ack != 3'b000) begin
         if (sb2.size() == 0) begin
            checkOutput("sb2_unexpected_ack", 8'(bus2.ack), 8'h00);
         end else begin
            e2 = sb2.pop_front();
            checkOutput("sb2_ack", 8'(bus2.ack), 8'(e2.g));
            checkOutput("sb2_addr", 8'(bus2.RAM_ADDR), 8'(e2.a));
         end
      end
   end

   task automatic applyStimulus(input logic a, input logic p, input logic r,
                                input logic [4:0] aa, input logic [4:0] pa, input logic [4:0] ra);
      bus0.alu_wr_req  = a;
      bus0.port_wr_req = p;
      bus0.rd_req      = r;
      bus0.alu_addr    = aa;
      bus0.port_addr   = pa;
      bus0.rd_addr     = ra;
   endtask

   task automatic waitAcks0(input int target, input int budget, input bit dropOnAck);
      int n   = 0;
      int cyc = 0;
      while (n < target && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (bus0.ack != 3'b000) begin
            n++;
            if (dropOnAck) begin
               if (bus0.ack[0]) bus0.alu_wr_req  = 1'b0;
               if (bus0.ack[1]) bus0.port_wr_req = 1'b0;
               if (bus0.ack[2]) bus0.rd_req      = 1'b0;
            end
         end
      end
      checkOutput("ack_count", 8'(n), 8'(target));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int ackSeen;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00);
      bus2.alu_wr_req  = 1'b0;
      bus2.port_wr_req = 1'b0;
      bus2.rd_req      = 1'b0;
      bus2.alu_addr    = 5'h00;
      bus2.port_addr   = 5'h00;
      bus2.rd_addr     = 5'h00;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_gnt", 8'(bus0.gnt), 8'h00);
      checkOutput("rst_addr", 8'(bus0.RAM_ADDR), 8'h00);
      checkOutput("rst_busy", 8'(bus0.busy), 8'h00);
      checkOutput("rst_cs", 8'(bus0.RAM_CS), 8'h00);
      rst = 1'b0;

      // ALU write, no wait states
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'h0A, 5'h00, 5'h00);
      sb0.push_back('{g: 3'b001, a: 5'h0A});
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) begin
            checkOutput("t1_gnt", 8'(bus0.gnt), 8'h01);
            checkOutput("t1_addr", 8'(bus0.RAM_ADDR), 8'h0A);
         end
         checkOutput("t1_stb", 8'(bus0.WR_STB), 8'(i == 2));
         checkOutput("t1_drv", 8'(bus0.ALU_DRV_EN), 8'(i <= 3));
         checkOutput("t1_cs", 8'(bus0.RAM_CS), 8'(i <= 3));
         checkOutput("t1_ack", 8'(bus0.ack), (i == 4) ? 8'h01 : 8'h00);
         checkOutput("t1_busyv", 8'(bus0.busy), 8'(i <= 4));
         if (i == 4) bus0.alu_wr_req = 1'b0;
      end

      // Read into RDR with two wait states
      bus2.rd_req  = 1'b1;
      bus2.rd_addr = 5'h1F;
      sb2.push_back('{g: 3'b100, a: 5'h1F});
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 1) begin
            checkOutput("t2_gnt", 8'(bus2.gnt), 8'h04);
            checkOutput("t2_addr", 8'(bus2.RAM_ADDR), 8'h1F);
         end
         checkOutput("t2_oe", 8'(bus2.RAM_OE), 8'(i >= 2 && i <= 5));
         checkOutput("t2_rdr", 8'(bus2.RDR_EN), 8'(i == 5));
         checkOutput("t2_cs", 8'(bus2.RAM_CS), 8'(i <= 5));
         checkOutput("t2_drv", 8'(bus2.ALU_DRV_EN | bus2.PORT_DRV_EN), 8'h00);
         checkOutput("t2_ack", 8'(bus2.ack), (i == 6) ? 8'h04 : 8'h00);
         if (i == 6) bus2.rd_req = 1'b0;
      end

      // All three requesters held from reset: alu, port, rd, alu
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 5'h01, 5'h02, 5'h03);
      sb0.push_back('{g: 3'b001, a: 5'h01});
      sb0.push_back('{g: 3'b010, a: 5'h02});
      sb0.push_back('{g: 3'b100, a: 5'h03});
      sb0.push_back('{g: 3'b001, a: 5'h01});
      @(negedge clk);
      rst = 1'b0;
      waitAcks0(4, 40, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00);
      @(negedge clk);

      // Reset during the strobe of a port write
      applyStimulus(1'b0, 1'b1, 1'b0, 5'h00, 5'h07, 5'h00);
      @(negedge clk);
      checkOutput("t4_gnt", 8'(bus0.gnt), 8'h02);
      checkOutput("t4_pdrv", 8'(bus0.PORT_DRV_EN), 8'h01);
      @(negedge clk);
      checkOutput("t4_stb", 8'(bus0.WR_STB), 8'h01);
      #2 rst = 1'b1;
      #1;
      checkOutput("t4_rst_stb", 8'(bus0.WR_STB), 8'h00);
      checkOutput("t4_rst_cs", 8'(bus0.RAM_CS), 8'h00);
      checkOutput("t4_rst_pdrv", 8'(bus0.PORT_DRV_EN), 8'h00);
      checkOutput("t4_rst_gnt", 8'(bus0.gnt), 8'h00);
      checkOutput("t4_rst_ack", 8'(bus0.ack), 8'h00);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'h04, 5'h07, 5'h00);
      sb0.push_back('{g: 3'b001, a: 5'h04});
      sb0.push_back('{g: 3'b010, a: 5'h07});
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t4_first_gnt", 8'(bus0.gnt), 8'h01);
      waitAcks0(2, 30, 1'b1);
      @(negedge clk);

      // Port drops its request during SETUP
      applyStimulus(1'b0, 1'b1, 1'b0, 5'h00, 5'h15, 5'h00);
      sb0.push_back('{g: 3'b010, a: 5'h15});
      ackSeen = 0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 1) begin
            checkOutput("t5_gnt", 8'(bus0.gnt), 8'h02);
            bus0.port_wr_req = 1'b0;
         end
         if (bus0.ack != 3'b000) ackSeen++;
         if (i == 4) checkOutput("t5_ack", 8'(bus0.ack), 8'h02);
         if (i >= 5) begin
            checkOutput("t5_idle_busy", 8'(bus0.busy), 8'h00);
            checkOutput("t5_idle_gnt", 8'(bus0.gnt), 8'h00);
         end
      end
      checkOutput("t5_ack_once", 8'(ackSeen), 8'h01);

      checkOutput("sb0_drained", 8'(sb0.size()), 8'h00);
      checkOutput("sb2_drained", 8'(sb2.size()), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
